// File: rtl/delay_lane_cal.sv
// Delay-code calibration for a 4-lane skew-compensation stage: sweeps each lane's code
// until the training marker lands a fixed number of cycles after the undelayed strobe.
module delay_lane_cal #(
  parameter logic [15:0] MARKER  = 16'hA55A,
  parameter int unsigned TARGET  = 8,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned MATCHES = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [65:0] din,
  output logic [15:0] cfg,
  output logic        busy,
  output logic        done,
  output logic [3:0]  fail
);

  // state     | meaning
  // IDLE      | waiting for start after reset
  // SETTLE    | code just changed, letting the delay line refill
  // WAIT_STB  | waiting for a strobe, bounded by the timeout
  // CHECK     | counting down to the expected marker cycle
  // ADVANCE   | miss: step the code or give up on the lane
  // NEXT_LANE | lane finished, move on or finish
  // DONE      | results held until the next start
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_STB, S_CHECK, S_ADVANCE, S_NEXT_LANE, S_DONE
  } state_t;

  localparam logic [15:0] SETTLE_LD  = 16'(SETTLE - 1);
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);
  localparam logic [15:0] TARGET_LD  = 16'(TARGET - 1);
  localparam logic [3:0]  MATCH_N    = 4'(MATCHES);

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [3:0]  hits_q, hits_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] cfg_q, cfg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  fail_q, fail_d;

  logic        strobe;
  logic [15:0] lane_word;
  logic [1:0]  lane_nx;

  assign strobe    = din[65] & din[64];
  assign lane_word = din[{lane_q, 4'b0000} +: 16];
  assign lane_nx   = lane_q + 2'd1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    hits_d  = hits_q;
    lane_d  = lane_q;
    code_d  = code_q;
    cfg_d   = cfg_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lane_d  = 2'd0;
          code_d  = 4'd0;
          cfg_d   = 16'h0000;
          fail_d  = 4'h0;
          hits_d  = 4'd0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          tmr_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == 16'd0) begin
          tmr_d   = TIMEOUT_LD;
          state_d = S_WAIT_STB;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_WAIT_STB: begin
        if (strobe) begin
          tmr_d   = TARGET_LD;
          state_d = S_CHECK;
        end else if (tmr_q == 16'd0) begin
          state_d = S_ADVANCE;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_CHECK: begin
        // terminal count lands exactly TARGET cycles after the strobe
        if (tmr_q == 16'd0) begin
          if (din[64] && (lane_word == MARKER)) begin
            hits_d = hits_q + 4'd1;
            if (hits_q + 4'd1 == MATCH_N) begin
              state_d = S_NEXT_LANE;
            end else begin
              tmr_d   = TIMEOUT_LD;
              state_d = S_WAIT_STB;
            end
          end else begin
            state_d = S_ADVANCE;
          end
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_ADVANCE: begin
        hits_d = 4'd0;
        if (code_q == 4'd15) begin
          fail_d[lane_q]               = 1'b1;
          cfg_d[{lane_q, 2'b00} +: 4] = 4'd0;
          state_d                      = S_NEXT_LANE;
        end else begin
          code_d                       = code_q + 4'd1;
          cfg_d[{lane_q, 2'b00} +: 4] = code_q + 4'd1;
          tmr_d                        = SETTLE_LD;
          state_d                      = S_SETTLE;
        end
      end
      S_NEXT_LANE: begin
        hits_d = 4'd0;
        if (lane_q == 2'd3) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          lane_d                        = lane_nx;
          code_d                        = 4'd0;
          cfg_d[{lane_nx, 2'b00} +: 4] = 4'd0;
          tmr_d                         = SETTLE_LD;
          state_d                       = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      tmr_q   <= 16'd0;
      hits_q  <= 4'd0;
      lane_q  <= 2'd0;
      code_q  <= 4'd0;
      cfg_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      hits_q  <= hits_d;
      lane_q  <= lane_d;
      code_q  <= code_d;
      cfg_q   <= cfg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign cfg  = cfg_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_delay_lane_cal.sv
// Bench for delay_lane_cal: an idealised delay stage (delay = code+1) feeds two calibrators
// (MATCHES=4 and MATCHES=1); final codes/flags are compared against a per-lane outcome model.
module tb_delay_lane_cal;

  localparam int TGT = 8;
  localparam int STL = 16;
  localparam int TMO = 64;
  localparam int P   = 20;
  localparam logic [15:0] MRK = 16'hA55A;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [65:0] din_a, din_b;
  logic [15:0] cfg_a, cfg_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [3:0]  fail_a, fail_b;

  delay_lane_cal #(.MARKER(MRK), .TARGET(TGT), .SETTLE(STL), .MATCHES(4), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .din(din_a),
    .cfg(cfg_a), .busy(busy_a), .done(done_a), .fail(fail_a)
  );

  delay_lane_cal #(.MARKER(MRK), .TARGET(TGT), .SETTLE(STL), .MATCHES(1), .TIMEOUT(TMO)) dut_m1 (
    .aclk(aclk), .areset(areset), .start(start), .din(din_b),
    .cfg(cfg_b), .busy(busy_b), .done(done_b), .fail(fail_b)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap = 0;
  int need[4];
  bit strobe_en;
  int spoil;      // 0 none, 1 corrupt 3rd used marker of lane 0, 2 valid low at lane 1 compares
  bit pulse;
  int t0[2];
  int nstb[2];
  int cat[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  always @(negedge aclk)
    if ((done_a && busy_a) || (done_b && busy_b)) overlap++;

  // Source plus delay stage: the strobe is every P cycles; lane j's marker reaches the
  // calibrator TARGET cycles after the strobe only when its code equals need[j].
  task automatic gen(input int i, input logic [15:0] cf, input logic bz, output logic [65:0] d);
    int  c;
    bit  stb, corrupt, vlow;
    logic [31:0] w;
    c = cyc;
    stb = strobe_en && (c % P == 0);
    corrupt = 1'b0;
    vlow = 1'b0;
    if (spoil == 1) begin
      if (bz && int'(cf[3:0]) == need[0] && t0[i] < 0) t0[i] = c;
      if (t0[i] >= 0 && stb && c >= t0[i] + STL) begin
        nstb[i]++;
        if (nstb[i] == 3) cat[i] = c + TGT;
      end
      corrupt = (c == cat[i]);
    end
    if (spoil == 2 && int'(cf[7:4]) == need[1] && (c % P) == TGT) vlow = 1'b1;
    d[65] = stb;
    d[64] = ~vlow;
    for (int j = 0; j < 4; j++) begin
      w = $urandom;
      if (w[15:0] == MRK) w[0] = ~w[0];
      if (need[j] >= 0 && !(corrupt && j == 0) &&
          ((c + 4*P - TGT + need[j] - int'(cf[4*j +: 4])) % P == 0))
        d[16*j +: 16] = MRK;
      else
        d[16*j +: 16] = w[15:0];
    end
  endtask

  initial begin
    din_a = '0;
    din_b = '0;
    forever begin
      @(negedge aclk);
      gen(0, cfg_a, busy_a, din_a);
      gen(1, cfg_b, busy_b, din_b);
    end
  end

  function automatic void model(input int m, output logic [15:0] ec, output logic [3:0] ef);
    bit ok;
    ec = 16'h0000;
    ef = 4'h0;
    for (int j = 0; j < 4; j++) begin
      ok = strobe_en && need[j] >= 0;
      if (spoil == 1 && j == 0 && m >= 3) ok = 1'b0;
      if (spoil == 2 && j == 1) ok = 1'b0;
      if (ok) ec[4*j +: 4] = 4'(need[j]);
      else    ef[j] = 1'b1;
    end
  endfunction

  task automatic run_cal(input string tag, output int elapsed);
    int n, ma, mb;
    ma = -1;
    mb = -1;
    @(negedge aclk);
    t0 = '{-1, -1};
    nstb = '{0, 0};
    cat = '{-1, -1};
    start = 1'b1;
    n = cyc;
    @(negedge aclk);
    start = 1'b0;
    check({tag, "_ack_done"}, 32'(done_a), 32'd0);
    check({tag, "_ack_busy"}, 32'(busy_a), 32'd1);
    for (int k = 0; k < 20000 && (ma < 0 || mb < 0); k++) begin
      if (done_a && ma < 0) ma = cyc;
      if (done_b && mb < 0) mb = cyc;
      if (pulse && busy_a && busy_b && start == 1'b0 && $urandom_range(0, 49) == 0) start = 1'b1;
      else start = 1'b0;
      @(negedge aclk);
    end
    start = 1'b0;
    check({tag, "_finished"}, 32'(ma >= 0 && mb >= 0), 32'd1);
    elapsed = ma - n - 1;
  endtask

  task automatic check_result(input string tag);
    logic [15:0] ec;
    logic [3:0]  ef;
    model(4, ec, ef);
    check({tag, "_cfg"},  32'(cfg_a),  32'(ec));
    check({tag, "_fail"}, 32'(fail_a), 32'(ef));
    check({tag, "_done"}, 32'(done_a), 32'd1);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    model(1, ec, ef);
    check({tag, "_m1_cfg"},  32'(cfg_b),  32'(ec));
    check({tag, "_m1_fail"}, 32'(fail_b), 32'(ef));
  endtask

  task automatic set_need(input int a, input int b, input int c, input int d);
    need[0] = a; need[1] = b; need[2] = c; need[3] = d;
  endtask

  initial begin
    int el;
    areset = 1'b1;
    start = 1'b0;
    strobe_en = 1'b1;
    spoil = 0;
    pulse = 1'b0;
    set_need(0, 3, 6, 9);
    t0 = '{-1, -1};
    nstb = '{0, 0};
    cat = '{-1, -1};
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_cfg",  32'(cfg_a),  32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_fail", 32'(fail_a), 32'h0);

    run_cal("s1", el);
    check("s1_cfg_const", 32'(cfg_a), 32'h9630);
    check_result("s1");

    for (int r = 0; r < 3; r++) begin
      set_need($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      run_cal("rnd", el);
      check_result("rnd");
    end

    set_need(0, 3, -1, 9);
    run_cal("s2", el);
    check_result("s2");

    strobe_en = 1'b0;
    run_cal("s3", el);
    check_result("s3");
    check("s3_dur", 32'(el), 32'(64 * (STL + TMO + 2) + 4));
    strobe_en = 1'b1;

    for (int r = 0; r < 2; r++) begin
      spoil = 1;
      set_need((r == 0) ? 3 : $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
      run_cal("s4", el);
      check_result("s4");
      spoil = 0;
    end

    set_need(0, 3, 6, 9);
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int k = 0; k < 5000 && !(busy_a && cfg_a[7:4] == 4'd2); k++) @(negedge aclk);
    check("s5_reach", 32'(busy_a && cfg_a[7:4] == 4'd2), 32'd1);
    #2 areset = 1'b1;
    #1;
    check("s5_cfg",  32'(cfg_a),  32'h0);
    check("s5_busy", 32'(busy_a), 32'h0);
    check("s5_done", 32'(done_a), 32'h0);
    check("s5_fail", 32'(fail_a), 32'h0);
    @(negedge aclk);
    areset = 1'b0;
    run_cal("s5r", el);
    check_result("s5r");

    spoil = 2;
    pulse = 1'b1;
    set_need($urandom_range(0, 15), 3, $urandom_range(0, 15), $urandom_range(0, 15));
    run_cal("s6", el);
    check_result("s6");
    spoil = 0;
    pulse = 1'b0;

    check("done_busy_excl", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
